// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 matrix keypad, debounces presses and releases,
// and presents a held key code plus a one-cycle accept strobe.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key,
  output logic       key_strobe
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [DW-1:0] DWELL_END = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_END = CW'(DEBOUNCE_CYC - 1);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;
  state_t state_q, state_d;
  logic [3:0] s1_q, rs_q, pat_q, pat_d, key_q, key_d, code;
  logic [1:0] ci_q, ci_d, ci_next, rix;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic strobe_q, strobe_d, valid;
  assign valid = (rs_q == 4'b1110) || (rs_q == 4'b1101) || (rs_q == 4'b1011) || (rs_q == 4'b0111);
  assign ci_next = (ci_q == 2'd2) ? 2'd0 : ci_q + 2'd1;
  assign rix = !pat_q[0] ? 2'd0 : !pat_q[1] ? 2'd1 : !pat_q[2] ? 2'd2 : 2'd3;
  // bottom row holds '*', '0', '#' which break the r*3+c+1 digit pattern
  assign code = (rix == 2'd3) ? ((ci_q == 2'd0) ? 4'd11 : (ci_q == 2'd1) ? 4'd0 : 4'd12)
                              : 4'(rix) * 4'd3 + 4'(ci_q) + 4'd1;
  always_comb begin
    state_d = state_q;
    ci_d = ci_q;
    dwell_d = dwell_q;
    cnt_d = cnt_q;
    pat_d = pat_q;
    key_d = key_q;
    strobe_d = 1'b0;
    case (state_q)
      SCAN:
        if (dwell_q == DWELL_END) begin
          dwell_d = '0;
          if (valid) begin
            state_d = DEBOUNCE;
            pat_d = rs_q;
            cnt_d = '0;
          end else
            ci_d = ci_next;
        end else
          dwell_d = dwell_q + 1'b1;
      DEBOUNCE:
        if (rs_q != pat_q) begin
          state_d = SCAN;
          ci_d = ci_next;
          dwell_d = '0;
        end else if (cnt_q == CNT_END) begin
          state_d = PRESSED;
          key_d = code;
          strobe_d = 1'b1;
          cnt_d = '0;
        end else
          cnt_d = cnt_q + 1'b1;
      default:
        if (rs_q != 4'hF)
          cnt_d = '0;
        else if (cnt_q == CNT_END) begin
          state_d = SCAN;
          key_d = 4'd10;
          ci_d = ci_next;
          dwell_d = '0;
          cnt_d = '0;
        end else
          cnt_d = cnt_q + 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 4'hF;
      rs_q <= 4'hF;
      state_q <= SCAN;
      ci_q <= 2'd0;
      dwell_q <= '0;
      cnt_q <= '0;
      pat_q <= 4'hF;
      key_q <= 4'd10;
      strobe_q <= 1'b0;
    end else begin
      s1_q <= row;
      rs_q <= s1_q;
      state_q <= state_d;
      ci_q <= ci_d;
      dwell_q <= dwell_d;
      cnt_q <= cnt_d;
      pat_q <= pat_d;
      key_q <= key_d;
      strobe_q <= strobe_d;
    end
  end
  assign col = ~(3'd1 << ci_q);
  assign key = key_q;
  assign key_strobe = strobe_q;
endmodule
